// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Entries carry the byte PC together with the fetched word.
package fetch_pkg;

  localparam int unsigned FETCH_PC_W   = 32;
  localparam int unsigned FETCH_DATA_W = 32;

  localparam logic [FETCH_PC_W-1:0] PC_STEP          = 32'd4;
  localparam logic [FETCH_PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [FETCH_PC_W-1:0] PC_ALIGN_MASK    = 32'd3;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]   pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [FETCH_PC_W-1:0] align_pc(
    input logic [FETCH_PC_W-1:0] pc
  );
    return pc & ~PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Output register plus one-entry skid for ROM responses.
// Keeps program order and absorbs one cycle of decode back-pressure.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  input  fetch_entry_t in_entry_i,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output fetch_entry_t out_entry_o,
  output logic         can_accept_next_o
);

  fetch_entry_t r_out;
  fetch_entry_t r_skid;
  logic         r_out_valid;
  logic         r_skid_valid;
  logic         w_out_free;

  assign w_out_free = !r_out_valid || out_ready_i;

  // A read issued now lands next cycle; refuse it if nowhere to put it.
  assign can_accept_next_o = !r_skid_valid &&
                             !(in_valid_i && r_out_valid && !out_ready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (in_valid_i) begin
      if (w_out_free) begin
        r_out_valid <= 1'b1;
        if (r_skid_valid) begin
          r_out  <= r_skid;
          r_skid <= in_entry_i;
        end else begin
          r_out <= in_entry_i;
        end
      end else begin
        r_skid       <= in_entry_i;
        r_skid_valid <= 1'b1;
      end
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_entry_o = r_out;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one ROM read per cycle,
// and hands words to decode through the skid buffer.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned         ADDR_WIDTH = 8,
  parameter int unsigned         DATA_WIDTH = FETCH_DATA_W,
  parameter int unsigned         PC_WIDTH   = FETCH_PC_W,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic                  fetch_en_i,
  input  logic                  redirect_i,
  input  logic [PC_WIDTH-1:0]   redirect_pc_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic [PC_WIDTH-1:0] r_resp_pc;
  logic                r_inflight;

  logic [PC_WIDTH-1:0] w_redirect_pc;
  logic                w_can_accept;
  logic                w_issue;
  logic                w_out_valid;
  fetch_entry_t        w_resp;
  fetch_entry_t        w_out;

  assign w_redirect_pc = align_pc(redirect_pc_i);
  assign w_issue       = fetch_en_i && !redirect_i && w_can_accept;
  assign w_resp        = '{pc: r_resp_pc, instr: rom_data_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= '0;
      r_inflight <= 1'b0;
    end else if (redirect_i) begin
      r_fetch_pc <= w_redirect_pc;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_resp_pc  <= r_fetch_pc;
      r_fetch_pc <= r_fetch_pc + PC_STEP;
      r_inflight <= 1'b1;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  // Truncation aliases PCs beyond ROM depth back onto the ROM.
  assign rom_addr_o = r_fetch_pc[ADDR_WIDTH+1:2];

  fetch_skid_buf u_skid (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .flush_i           (redirect_i),
    .in_valid_i        (r_inflight),
    .in_entry_i        (w_resp),
    .out_ready_i       (ready_i),
    .out_valid_o       (w_out_valid),
    .out_entry_o       (w_out),
    .can_accept_next_o (w_can_accept)
  );

  assign valid_o = w_out_valid;
  assign instr_o = w_out.instr;
  assign pc_o    = w_out.pc;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus random traffic
// checked against a transaction-level expected-PC stream.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic        ready;

  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;

  instr_fetch_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .fetch_en_i    (fetch_en),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_o       (instr),
    .pc_o          (pc),
    .valid_o       (valid),
    .ready_i       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + {24'd0, a[9:2]};
  endfunction

  // Synchronous ROM: one-cycle read latency.
  always @(posedge clk) rom_data <= rom_word({22'd0, rom_addr, 2'b00});

  function automatic void check(string tag, logic [63:0] got,
                                logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endfunction

  logic [31:0] exp_pc;
  logic        p_valid, p_ready, p_redir;
  logic [31:0] p_pc, p_instr;

  // Each accepted word must be the next PC of program order.
  always @(negedge clk) begin
    if (rst) begin
      exp_pc  = 32'h0;
      p_valid = 1'b0;
      p_ready = 1'b0;
      p_redir = 1'b0;
    end else begin
      if (p_valid && !p_ready && !p_redir) begin
        check("hold_valid", 64'(valid), 64'd1);
        if (valid) begin
          check("hold_pc", 64'(pc), 64'(p_pc));
          check("hold_instr", 64'(instr), 64'(p_instr));
        end
      end
      if (valid && ready) begin
        check("acc_pc", 64'(pc), 64'(exp_pc));
        check("acc_instr", 64'(instr), 64'(rom_word(exp_pc)));
        exp_pc = exp_pc + 32'd4;
        n_acc++;
      end
      if (redirect) exp_pc = redirect_pc & ~32'h3;
      p_valid = valid;
      p_ready = ready;
      p_redir = redirect;
      p_pc    = pc;
      p_instr = instr;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(output logic [31:0] got_pc);
    bit found = 0;
    got_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid && ready) begin
        found  = 1;
        got_pc = pc;
      end
      nxt();
      if (found) break;
    end
    if (!found) check("wait_acc_timeout", 64'd0, 64'd1);
  endtask

  task automatic reset_start();
    @(negedge clk); check("c0_valid", 64'(valid), 64'd0); nxt();
    @(negedge clk); check("c1_valid", 64'(valid), 64'd0); nxt();
    @(negedge clk);
    check("c2_valid", 64'(valid), 64'd1);
    check("c2_pc", 64'(pc), 64'h0);
    check("c2_instr", 64'(instr), 64'h1000_0000);
    nxt();
  endtask

  task automatic redir_check(logic [31:0] tgt, logic [31:0] raw);
    redirect    = 1'b1;
    redirect_pc = raw;
    @(negedge clk); nxt();
    redirect = 1'b0;
    ready    = 1'b1;
    @(negedge clk); check("r1_valid", 64'(valid), 64'd0); nxt();
    @(negedge clk); check("r2_valid", 64'(valid), 64'd0); nxt();
    @(negedge clk);
    check("r3_valid", 64'(valid), 64'd1);
    check("r3_pc", 64'(pc), 64'(tgt));
    check("r3_instr", 64'(instr), 64'(rom_word(tgt)));
    nxt();
  endtask

  logic [31:0] got, last, a0;
  int cnt;

  initial begin
    rst         = 1'b1;
    ready       = 1'b1;
    fetch_en    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    rst = 1'b0;

    reset_start();
    @(negedge clk); check("c3_pc", 64'(pc), 64'h4); nxt();
    ready = 1'b0;
    @(negedge clk); check("stall_pc", 64'(pc), 64'h8); nxt();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_addr", 64'(rom_addr), 64'd4);
      check("stall_pc_held", 64'(pc), 64'h8);
      nxt();
    end
    ready = 1'b1;
    @(negedge clk); check("rel_pc8", 64'(pc), 64'h8); nxt();
    @(negedge clk); check("rel_pc12", 64'(pc), 64'hC); nxt();
    wait_acc(got);
    check("rel_pc16", 64'(got), 64'h10);

    repeat (4) begin @(negedge clk); nxt(); end
    ready = 1'b0;
    repeat (3) begin @(negedge clk); nxt(); end
    redir_check(32'h40, 32'h40);

    repeat (3) begin @(negedge clk); nxt(); end
    redir_check(32'h40, 32'h43);

    repeat (3) begin @(negedge clk); nxt(); end
    fetch_en = 1'b0;
    cnt  = 0;
    last = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid && ready) begin
        if (i > 0) cnt++;
        last = pc;
      end
      nxt();
    end
    check("halt_extra_le1", 64'(cnt <= 1), 64'd1);
    @(negedge clk);
    check("halt_valid", 64'(valid), 64'd0);
    a0 = {24'd0, rom_addr};
    nxt();
    @(negedge clk);
    check("halt_addr", 64'(rom_addr), 64'(a0));
    nxt();
    fetch_en = 1'b1;
    wait_acc(got);
    check("resume_pc", 64'(got), 64'(last + 32'd4));

    redirect    = 1'b1;
    redirect_pc = 32'h3F8;
    @(negedge clk); nxt();
    redirect = 1'b0;
    @(negedge clk); check("wrap_a254", 64'(rom_addr), 64'd254); nxt();
    @(negedge clk); check("wrap_a255", 64'(rom_addr), 64'd255); nxt();
    @(negedge clk);
    check("wrap_a0", 64'(rom_addr), 64'd0);
    check("wrap_pc3f8", 64'(pc), 64'h3F8);
    nxt();
    @(negedge clk); check("wrap_pc3fc", 64'(pc), 64'h3FC); nxt();
    @(negedge clk);
    check("wrap_pc400", 64'(pc), 64'h400);
    check("wrap_instr", 64'(instr), 64'h1000_0000);
    nxt();

    ready = 1'b0;
    repeat (3) begin @(negedge clk); nxt(); end
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(valid), 64'd0);
    check("arst_pc", 64'(pc), 64'd0);
    nxt();
    rst   = 1'b0;
    ready = 1'b1;
    reset_start();

    cnt = n_acc;
    for (int i = 0; i < 3000; i++) begin
      ready       = ($urandom % 4) != 0;
      fetch_en    = ($urandom % 10) != 0;
      redirect    = ($urandom % 32) == 0;
      redirect_pc = $urandom & 32'h7FF;
      @(negedge clk);
      nxt();
    end
    redirect = 1'b0;
    ready    = 1'b1;
    fetch_en = 1'b1;
    repeat (5) begin @(negedge clk); nxt(); end
    check("rand_progress", 64'(n_acc - cnt > 500), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
